// File: rtl/pipe_stage_exe_md.sv
// Execute stage: operand muxing, ALU, JAL link path and an iterative
// one-bit-per-cycle multiply/divide unit with HI/LO registers.
module pipe_stage_exe_md #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5,
    parameter int unsigned CW    = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             evalid,
    input  logic [3:0]       ealuc,
    input  logic [2:0]       emd,
    input  logic             ealuimm,
    input  logic             eshift,
    input  logic             ejal,
    input  logic [WIDTH-1:0] ea,
    input  logic [WIDTH-1:0] eb,
    input  logic [WIDTH-1:0] eimm,
    input  logic [WIDTH-1:0] epc4,
    input  logic [4:0]       ern0,
    output logic [WIDTH-1:0] ealu,
    output logic [4:0]       ern,
    output logic             estall,
    output logic             ebusy
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;     // product high half / partial remainder
    logic [WIDTH-1:0]   mq_q, mq_d;       // multiplier / dividend-quotient
    logic [WIDTH-1:0]   opb_q, opb_d;     // multiplicand / divisor magnitude
    logic               div_q, div_d;
    logic               negp_q, negp_d;   // negate product or quotient
    logic               negr_q, negr_d;   // negate remainder
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               md_start, md_class, md_signed, md_divop, issue;
    logic               a_neg, b_neg, div_zero;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH-1:0]   alu_a, alu_b, alu_y;
    logic [SHW-1:0]     shamt;
    logic [WIDTH:0]     mul_sum, div_sh, div_tr;
    logic [WIDTH-1:0]   acc_n, mq_n;
    logic [2*WIDTH-1:0] prod;

    // Operation decode, issue/stall and operand magnitude preparation
    always_comb begin
        md_start  = (emd >= 3'd1) && (emd <= 3'd4);
        md_class  = (emd >= 3'd1) && (emd <= 3'd6);
        md_signed = (emd == 3'd1) || (emd == 3'd3);
        md_divop  = (emd == 3'd3) || (emd == 3'd4);
        ebusy     = (state_q == BUSY);
        estall    = evalid && md_class && ebusy;
        issue     = evalid && md_start && (state_q == IDLE);
        a_neg     = md_signed && ea[WIDTH-1];
        b_neg     = md_signed && eb[WIDTH-1];
        div_zero  = md_divop && (eb == '0);
        // Divide by zero runs as an unsigned divide of the raw ea by 0, which
        // naturally yields an all-ones quotient and the unmodified ea remainder.
        mag_a     = (a_neg && !div_zero) ? -ea : ea;
        mag_b     = b_neg ? -eb : eb;
    end

    // ALU with shift-amount / immediate operand muxing
    always_comb begin
        alu_a = eshift ? {{(WIDTH-SHW){1'b0}}, eimm[6+SHW-1:6]} : ea;
        alu_b = ealuimm ? eimm : eb;
        shamt = alu_a[SHW-1:0];
        case (ealuc)
            4'd0:    alu_y = alu_a + alu_b;
            4'd1:    alu_y = alu_a - alu_b;
            4'd2:    alu_y = alu_a & alu_b;
            4'd3:    alu_y = alu_a | alu_b;
            4'd4:    alu_y = alu_a ^ alu_b;
            4'd5:    alu_y = alu_b << (WIDTH/2);
            4'd6:    alu_y = alu_b << shamt;
            4'd7:    alu_y = alu_b >> shamt;
            4'd8:    alu_y = $signed(alu_b) >>> shamt;
            4'd9:    alu_y = {{(WIDTH-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            4'd10:   alu_y = {{(WIDTH-1){1'b0}}, alu_a < alu_b};
            default: alu_y = '0;
        endcase
    end

    // Result and destination selection
    always_comb begin
        if (ejal)
            ealu = epc4 + WIDTH'(4);
        else if (emd == 3'd5)
            ealu = hi_q;
        else if (emd == 3'd6)
            ealu = lo_q;
        else
            ealu = alu_y;
        ern = md_start ? 5'd0 : (ern0 | {5{ejal}});
    end

    // One iteration step: shift-add multiply or restoring divide
    always_comb begin
        mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : '0);
        div_sh  = {acc_q, mq_q[WIDTH-1]};
        div_tr  = div_sh - {1'b0, opb_q};
        if (div_q) begin
            if (!div_tr[WIDTH]) begin
                acc_n = div_tr[WIDTH-1:0];
                mq_n  = {mq_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = div_sh[WIDTH-1:0];
                mq_n  = {mq_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_n = mul_sum[WIDTH:1];
            mq_n  = {mul_sum[0], mq_q[WIDTH-1:1]};
        end
        prod = {acc_n, mq_n};
    end

    // Mul/div FSM next state and HI/LO write on completion
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        opb_d   = opb_q;
        div_d   = div_q;
        negp_d  = negp_q;
        negr_d  = negr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = BUSY;
                    cnt_d   = CW'(WIDTH);
                    acc_d   = '0;
                    mq_d    = mag_a;
                    opb_d   = mag_b;
                    div_d   = md_divop;
                    negp_d  = !div_zero && (a_neg ^ b_neg);
                    negr_d  = !div_zero && md_divop && a_neg;
                end
            end
            BUSY: begin
                acc_d = acc_n;
                mq_d  = mq_n;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    if (div_q) begin
                        lo_d = negp_q ? -mq_n : mq_n;
                        hi_d = negr_q ? -acc_n : acc_n;
                    end else begin
                        {hi_d, lo_d} = negp_q ? -prod : prod;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, working registers and HI/LO
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            opb_q   <= '0;
            div_q   <= 1'b0;
            negp_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            opb_q   <= opb_d;
            div_q   <= div_d;
            negp_q  <= negp_d;
            negr_q  <= negr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_exe_md.sv
// Self-checking bench for pipe_stage_exe_md (32-bit and 16-bit instances).
module tb_pipe_stage_exe_md;

    logic        clock = 1'b0;
    logic        reset;
    always #5 clock = ~clock;

    // 32-bit instance signals
    logic        evalid, ealuimm, eshift, ejal;
    logic [3:0]  ealuc;
    logic [2:0]  emd;
    logic [31:0] ea, eb, eimm, epc4, ealu;
    logic [4:0]  ern0, ern;
    logic        estall, ebusy;

    // 16-bit instance signals
    logic        s_evalid, s_ealuimm, s_eshift, s_ejal;
    logic [3:0]  s_ealuc;
    logic [2:0]  s_emd;
    logic [15:0] s_ea, s_eb, s_eimm, s_epc4, s_ealu;
    logic [4:0]  s_ern0, s_ern;
    logic        s_estall, s_ebusy;

    pipe_stage_exe_md u_dut32 (
        .clock(clock), .reset(reset), .evalid(evalid), .ealuc(ealuc), .emd(emd),
        .ealuimm(ealuimm), .eshift(eshift), .ejal(ejal), .ea(ea), .eb(eb),
        .eimm(eimm), .epc4(epc4), .ern0(ern0), .ealu(ealu), .ern(ern),
        .estall(estall), .ebusy(ebusy)
    );

    pipe_stage_exe_md #(.WIDTH(16), .SHW(4), .CW(5)) u_dut16 (
        .clock(clock), .reset(reset), .evalid(s_evalid), .ealuc(s_ealuc), .emd(s_emd),
        .ealuimm(s_ealuimm), .eshift(s_eshift), .ejal(s_ejal), .ea(s_ea), .eb(s_eb),
        .eimm(s_eimm), .epc4(s_epc4), .ern0(s_ern0), .ealu(s_ealu), .ern(s_ern),
        .estall(s_estall), .ebusy(s_ebusy)
    );

    int          n_err = 0;
    int          n_chk = 0;
    logic [63:0] sb_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] aluc, input logic [2:0] md,
                         input logic aluimm, input logic shift, input logic jal,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [31:0] pc4, input logic [4:0] rn0);
        evalid = v; ealuc = aluc; emd = md; ealuimm = aluimm; eshift = shift; ejal = jal;
        ea = a; eb = b; eimm = imm; epc4 = pc4; ern0 = rn0;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 5'd0);
    endtask

    // Reference HI:LO built from the language's own arithmetic operators
    function automatic logic [63:0] md_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        longint      la, lb;
        int          sa, sb;
        logic [31:0] q, r;
        case (op)
            3'd1: begin
                la = longint'($signed(a));
                lb = longint'($signed(b));
                return 64'(la * lb);
            end
            3'd2: return {32'd0, a} * {32'd0, b};
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sa = $signed(a);
                sb = $signed(b);
                q  = sa / sb;
                r  = sa % sb;
                return {r, q};
            end
            3'd4: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic wait_idle32(output int n);
        n = 0;
        while (ebusy === 1'b1 && n < 200) begin
            n++;
            cyc();
        end
    endtask

    task automatic read_hilo32(input string tag);
        logic [63:0] e;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb"}, 64'd0, 64'd1);
            return;
        end
        e = sb_q.pop_front();
        drive(1'b1, 4'd0, 3'd5, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 5'd2);
        @(negedge clock);
        check_eq({tag, "_hi"}, 64'(ealu), 64'(e[63:32]));
        cyc();
        drive(1'b1, 4'd0, 3'd6, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 5'd2);
        @(negedge clock);
        check_eq({tag, "_lo"}, 64'(ealu), 64'(e[31:0]));
        cyc();
        idle();
    endtask

    task automatic run_md32(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b);
        int n;
        drive(1'b1, 4'd0, op, 1'b0, 1'b0, 1'b0, a, b, '0, '0, 5'd3);
        sb_q.push_back(md_model(op, a, b));
        @(negedge clock);
        check_eq({tag, "_ern"}, 64'(ern), 64'd0);
        cyc();
        idle();
        wait_idle32(n);
        check_eq({tag, "_busy_len"}, 64'(n), 64'd32);
        read_hilo32(tag);
    endtask

    task automatic alu_chk(input string tag, input logic [3:0] aluc, input logic aluimm,
                           input logic shift, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic [31:0] exp);
        sb_q.push_back(64'(exp));
        drive(1'b1, aluc, 3'd0, aluimm, shift, 1'b0, a, b, imm, '0, 5'd7);
        @(negedge clock);
        check_eq(tag, 64'(ealu), sb_q.pop_front());
        check_eq({tag, "_ern"}, 64'(ern), 64'd7);
        cyc();
    endtask

    initial begin : main
        int          n;
        logic [63:0] e;

        reset = 1'b1;
        idle();
        s_evalid = 0; s_ealuc = 0; s_emd = 0; s_ealuimm = 0; s_eshift = 0; s_ejal = 0;
        s_ea = 0; s_eb = 0; s_eimm = 0; s_epc4 = 0; s_ern0 = 0;
        cyc();
        cyc();
        reset = 1'b0;

        // Reset state
        @(negedge clock);
        check_eq("rst_ebusy", 64'(ebusy), 64'd0);
        check_eq("rst_estall", 64'(estall), 64'd0);
        check_eq("rst_ebusy16", 64'(s_ebusy), 64'd0);
        cyc();
        drive(1'b1, 4'd0, 3'd5, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 5'd0);
        @(negedge clock);
        check_eq("rst_hi", 64'(ealu), 64'd0);
        check_eq("rst_mfhi_stall", 64'(estall), 64'd0);
        cyc();

        // ALU
        alu_chk("add_imm", 4'd0, 1'b1, 1'b0, 32'd5, 32'd99, 32'hFFFF_FFFF, 32'd4);
        alu_chk("sub", 4'd1, 1'b0, 1'b0, 32'd10, 32'd3, 32'd0, 32'd7);
        alu_chk("and", 4'd2, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 32'h00F0_00F0);
        alu_chk("or", 4'd3, 1'b0, 1'b0, 32'h0F00_0000, 32'h0000_00F0, 32'd0, 32'h0F00_00F0);
        alu_chk("xor", 4'd4, 1'b0, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'd0, 32'hF0F0_0F0F);
        alu_chk("lui", 4'd5, 1'b1, 1'b0, 32'd0, 32'd0, 32'h0000_1234, 32'h1234_0000);
        alu_chk("sll_sa", 4'd6, 1'b0, 1'b1, 32'hDEAD, 32'd1, 32'h0000_0100, 32'h10);
        alu_chk("srl_reg", 4'd7, 1'b0, 1'b0, 32'd8, 32'h8000_0000, 32'd0, 32'h0080_0000);
        alu_chk("sra_sa", 4'd8, 1'b0, 1'b1, 32'd0, 32'h8000_0000, 32'h0000_0100, 32'hF800_0000);
        alu_chk("slt", 4'd9, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1);
        alu_chk("sltu_1", 4'd10, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd1);
        alu_chk("sltu_0", 4'd10, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
        alu_chk("code13", 4'd13, 1'b0, 1'b0, 32'd5, 32'd5, 32'd0, 32'd0);

        // JAL
        drive(1'b1, 4'd0, 3'd0, 1'b0, 1'b0, 1'b1, 32'd1, 32'd2, '0, 32'h100, 5'd0);
        @(negedge clock);
        check_eq("jal_alu", 64'(ealu), 64'h104);
        check_eq("jal_ern", 64'(ern), 64'd31);
        check_eq("jal_stall", 64'(estall), 64'd0);
        cyc();

        // MULT -3*5 with a dependent MFLO held by estall
        drive(1'b1, 4'd0, 3'd1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFD, 32'd5, '0, '0, 5'd4);
        sb_q.push_back(md_model(3'd1, 32'hFFFF_FFFD, 32'd5));
        cyc();
        idle();
        @(negedge clock);
        check_eq("mult_busy_c1", 64'(ebusy), 64'd1);
        cyc();
        drive(1'b1, 4'd0, 3'd6, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 5'd2);
        n = 0;
        for (int c = 2; c <= 32; c++) begin
            @(negedge clock);
            if (estall === 1'b1 && ebusy === 1'b1) n++;
            cyc();
        end
        check_eq("mflo_stall_cycles", 64'(n), 64'd31);
        e = sb_q.pop_front();
        @(negedge clock);
        check_eq("c33_stall", 64'(estall), 64'd0);
        check_eq("c33_busy", 64'(ebusy), 64'd0);
        check_eq("mult_lo", 64'(ealu), 64'(e[31:0]));
        check_eq("mult_lo_const", 64'(ealu), 64'hFFFF_FFF1);
        cyc();
        drive(1'b1, 4'd0, 3'd5, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 5'd2);
        @(negedge clock);
        check_eq("mult_hi", 64'(ealu), 64'(e[63:32]));
        cyc();
        idle();

        // Divide cases and further multiplies
        run_md32("div_7_m2", 3'd3, 32'd7, 32'hFFFF_FFFE);
        run_md32("divu_by0", 3'd4, 32'd7, 32'd0);
        run_md32("div_min_m1", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_md32("div_m7_2", 3'd3, 32'hFFFF_FFF9, 32'd2);
        run_md32("div_by0_neg", 3'd3, 32'hFFFF_FFF9, 32'd0);
        run_md32("divu_big", 3'd4, 32'hFFFF_FFF0, 32'd7);
        run_md32("mult_neg_neg", 3'd1, 32'hFFFF_FF00, 32'h8000_0001);
        run_md32("multu_mix", 3'd2, 32'h1234_5678, 32'h9ABC_DEF0);

        // ADD proceeds during BUSY; back-to-back MULTU is held then issues
        drive(1'b1, 4'd0, 3'd1, 1'b0, 1'b0, 1'b0, 32'd6, 32'd7, '0, '0, 5'd4);
        cyc();
        drive(1'b1, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd2, 32'd3, '0, '0, 5'd9);
        @(negedge clock);
        check_eq("busy_add_stall", 64'(estall), 64'd0);
        check_eq("busy_add_alu", 64'(ealu), 64'd5);
        check_eq("busy_add_ern", 64'(ern), 64'd9);
        cyc();
        drive(1'b1, 4'd0, 3'd2, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, '0, 5'd4);
        sb_q.push_back(md_model(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
        n = 0;
        while (n < 100) begin
            @(negedge clock);
            if (estall !== 1'b1) break;
            n++;
            cyc();
        end
        check_eq("b2b_stall_cycles", 64'(n), 64'd31);
        cyc();
        idle();
        wait_idle32(n);
        check_eq("b2b_busy_len", 64'(n), 64'd32);
        e = sb_q[0];
        check_eq("b2b_model", e, 64'hFFFF_FFFE_0000_0001);
        read_hilo32("b2b_multu");

        // Reset in cycle 10 of a DIV clears state and HI/LO
        drive(1'b1, 4'd0, 3'd3, 1'b0, 1'b0, 1'b0, 32'd1000, 32'd7, '0, '0, 5'd4);
        cyc();
        idle();
        for (int c = 1; c < 10; c++) cyc();
        @(negedge clock);
        check_eq("pre_rst_busy", 64'(ebusy), 64'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        drive(1'b1, 4'd0, 3'd5, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 5'd2);
        @(negedge clock);
        check_eq("mid_rst_busy", 64'(ebusy), 64'd0);
        check_eq("mid_rst_hi", 64'(ealu), 64'd0);
        cyc();
        drive(1'b1, 4'd0, 3'd6, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 5'd2);
        @(negedge clock);
        check_eq("mid_rst_lo", 64'(ealu), 64'd0);
        cyc();
        idle();

        // 16-bit instance: SRA via shift amount, then MULTU 0xFFFF^2
        s_evalid = 1; s_ealuc = 4'd8; s_eshift = 1; s_eimm = 16'h0100; s_eb = 16'h8000;
        @(negedge clock);
        check_eq("w16_sra", 64'(s_ealu), 64'hF800);
        cyc();
        s_ealuc = 4'd0; s_eshift = 0; s_eimm = 0;
        s_emd = 3'd2; s_ea = 16'hFFFF; s_eb = 16'hFFFF;
        cyc();
        s_evalid = 0; s_emd = 3'd0;
        n = 0;
        while (s_ebusy === 1'b1 && n < 100) begin
            n++;
            cyc();
        end
        check_eq("w16_busy_len", 64'(n), 64'd16);
        s_evalid = 1; s_emd = 3'd5;
        @(negedge clock);
        check_eq("w16_hi", 64'(s_ealu), 64'hFFFE);
        cyc();
        s_emd = 3'd6;
        @(negedge clock);
        check_eq("w16_lo", 64'(s_ealu), 64'h0001);
        cyc();
        s_evalid = 0; s_emd = 3'd0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
